ncl_thxor0_bank: RTL
====================

# ncl_thxor0_bank

Clocked, parametrised functional model of a bank of WIDTH THxor0 threshold gates (y = AB + CD with hysteresis) for cycle-based simulation of NCL pipelines. It generalises the single reset-to-NULL gate with a selectable reset value, and adds bank-level completion detection, a four-phase wavefront monitor, a completed-wavefront counter and a sticky protocol-error flag. It sits between NCL combinational stages and the stage's completion/acknowledge logic in the functional-simulation environment.

## Interface
- WIDTH, 4: number of THxor0 gates in the bank (≥1).
- RST_VAL, 0: reset value of every gate output; 0 = "n" variant (NULL), 1 = "d" variant (DATA).
- CNT_W, 16: width of the wavefront counter.
- clk  in  1  sampling clock; all state updates on the rising edge.
- rsb  in  1  reset; asynchronous, active-low.
- a, b, c, d  in  WIDTH  per-gate inputs; bit i drives gate i.
- err_clr  in  1  clears the sticky error flag.
- y  out  WIDTH  gate outputs.
- all_data  out  1  completion: &y.
- all_null  out  1  completion: ~|y.
- phase  out  2  wavefront monitor state.
- wave_cnt  out  CNT_W  count of completed DATA wavefronts.
- err  out  1  sticky protocol-violation flag.

## Operation
- Per gate i, each rising edge: set_i = a&b | c&d; clr_i = ~(a|b|c|d).
  - set_i → y[i]←1; else clr_i → y[i]←0; else y[i] holds (hysteresis).
  - set_i and clr_i are mutually exclusive; no other priority is needed.
- all_data and all_null are combinational from the registered y. WIDTH=1: both reflect the single bit.
- Phase FSM, evaluated on the next-state value y_n:
  - NULL (0): all y=0. ~|y_n → stay. &y_n → DATA, wave_cnt+1. Otherwise → GROW.
  - GROW (1): some y set, not all. &y_n → DATA, wave_cnt+1. ~|y_n → NULL. Otherwise → stay.
  - DATA (2): all y=1. &y_n → stay. ~|y_n → NULL. Otherwise → SHRINK.
  - SHRINK (3): some cleared, not all. ~|y_n → NULL. &y_n → DATA, wave_cnt+1. Otherwise → stay.
- Protocol errors set err on the same edge:
  - In GROW, any bit falling 1→0.
  - In SHRINK, any bit rising 0→1.
  - GROW→NULL and SHRINK→DATA are also errors. Both set err, and the state still follows the transition rules above.
- Counter rules:
  - wave_cnt increments exactly once per entry into DATA. It never increments while remaining in DATA.
  - wave_cnt wraps from 2^CNT_W−1 to 0 with no flag.
- err is sticky. err_clr clears it on the next edge. If err_clr coincides with a new error, set wins (err stays 1).

## Timing
- Reset (rsb=0, asynchronous, immediate, including mid-wavefront):
  - y = {WIDTH{RST_VAL}}.
  - phase = DATA if RST_VAL=1, else NULL.
  - wave_cnt = 0, err = 0.
- Leaving reset does not count a wavefront.
- rsb is released synchronously to clk by the environment.
- Latency is 1 clk from input change to y, phase, wave_cnt and err. all_data/all_null follow y with zero additional delay.
- Inputs are sampled only at rising edges. Glitches between edges are invisible by design.

## Structure
- Package ncl_pkg holds:
  - the phase typedef: PH_NULL=0, PH_GROW=1, PH_DATA=2, PH_SHRINK=3;
  - the localparams for the set/clear encodings.
  - No other shared content.
- Sub-module thxor0_cell: one hysteresis flop with ports clk, rsb, a, b, c, d, y and parameter RST_VAL. It is instantiated WIDTH times by generate.
- The bank module owns the completion reduction, the phase FSM, wave_cnt and err.

## Test plan
- Reset, WIDTH=4, RST_VAL=0: rsb low → y=0000, phase=NULL, wave_cnt=0, err=0. Then a=b=1111 for 1 clk → y=1111, phase=DATA, wave_cnt=1.
- Hysteresis: y=0001 with gate 0 at a=b=1; change gate 0 to a=1,b=0,c=d=0 → y[0] holds 1. Then all gate-0 inputs 0 → y[0]=0 next edge.
- Full four-phase cycle:
  - set gates one per clk → phase NULL→GROW→GROW→GROW→DATA, wave_cnt=1;
  - clear one per clk → DATA→SHRINK…→NULL, err=0.
- Protocol error: in GROW (y=0011), clear gate 0 → err=1, y=0010, phase stays GROW. Assert err_clr together with another fall → err stays 1. err_clr alone → err=0.
- Counter wrap, CNT_W=2: four full wavefronts → wave_cnt 1,2,3,0.
- RST_VAL=1 and mid-op reset: from reset y=1111, phase=DATA, wave_cnt=0. Reset asserted in GROW → outputs return to reset values within the same cycle, before the next clk edge.

Source files
------------

// File: rtl/ncl_pkg.sv
// Shared types for the NCL THxor0 bank: wavefront phase and per-gate action codes.
// Latency: none (types and constants only).
// Backpressure: none.
package ncl_pkg;

    // Wavefront monitor state, as seen on the bank's phase output.
    typedef enum logic [1:0] {
        PH_NULL   = 2'd0,
        PH_GROW   = 2'd1,
        PH_DATA   = 2'd2,
        PH_SHRINK = 2'd3
    } phase_t;

    // Per-gate action decoded from the four inputs on each edge.
    localparam logic [1:0] GATE_HOLD = 2'b00;
    localparam logic [1:0] GATE_SET  = 2'b01;
    localparam logic [1:0] GATE_CLR  = 2'b10;

endpackage

// File: rtl/thxor0_cell.sv
// One THxor0 threshold gate (y = AB + CD) with hysteresis, modelled as a flop.
// Latency: 1 clk from inputs to y.
// Backpressure: none; inputs are sampled every rising edge.
module thxor0_cell
    import ncl_pkg::*;
#(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rsb,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic y
);

    logic [1:0] act;

    // Decode set (either product term true) / clear (all inputs NULL) / hold.
    always_comb begin
        act = GATE_HOLD;
        if ((a & b) | (c & d)) begin
            act = GATE_SET;
        end else if (~(a | b | c | d)) begin
            act = GATE_CLR;
        end
    end

    // Hysteresis flop: output only moves on a full set or a full clear.
    always_ff @(posedge clk or negedge rsb) begin
        if (!rsb) begin
            y <= RST_VAL;
        end else begin
            case (act)
                GATE_SET: y <= 1'b1;
                GATE_CLR: y <= 1'b0;
                default:  y <= y;
            endcase
        end
    end

endmodule

// File: rtl/ncl_thxor0_bank.sv
// Bank of WIDTH THxor0 gates with completion detect, four-phase wavefront monitor, wave counter, sticky error.
// Latency: 1 clk from inputs to y/phase/wave_cnt/err; all_data/all_null are combinational from y.
// Backpressure: none; the bank observes the NCL handshake and never stalls it.
module ncl_thxor0_bank
    import ncl_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter bit RST_VAL = 1'b0,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rsb,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             err_clr,
    output logic [WIDTH-1:0] y,
    output logic             all_data,
    output logic             all_null,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] wave_cnt,
    output logic             err
);

    localparam phase_t PH_RST = RST_VAL ? PH_DATA : PH_NULL;

    phase_t           ph_q;
    logic [WIDTH-1:0] set_v;
    logic [WIDTH-1:0] clr_v;
    logic [WIDTH-1:0] y_n;
    logic             n_full;
    logic             n_empty;
    logic             any_fall;
    logic             any_rise;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            thxor0_cell #(
                .RST_VAL (RST_VAL)
            ) u_cell (
                .clk (clk),
                .rsb (rsb),
                .a   (a[gi]),
                .b   (b[gi]),
                .c   (c[gi]),
                .d   (d[gi]),
                .y   (y[gi])
            );
        end
    endgenerate

    // Mirror the cells' next state so the monitor can act on the same edge the gates move.
    always_comb begin
        set_v    = (a & b) | (c & d);
        clr_v    = ~(a | b | c | d);
        y_n      = set_v | (y & ~clr_v);
        n_full   = &y_n;
        n_empty  = ~|y_n;
        any_fall = |(y & ~y_n);
        any_rise = |(~y & y_n);
    end

    assign all_data = &y;
    assign all_null = ~|y;
    assign phase    = ph_q;

    // Wavefront FSM with counter and sticky error; a new error beats err_clr.
    always_ff @(posedge clk or negedge rsb) begin
        if (!rsb) begin
            ph_q     <= PH_RST;
            wave_cnt <= '0;
            err      <= 1'b0;
        end else begin
            logic err_evt;
            err_evt = 1'b0;
            case (ph_q)
                PH_NULL: begin
                    if (n_full) begin
                        ph_q     <= PH_DATA;
                        wave_cnt <= wave_cnt + CNT_W'(1);
                    end else if (!n_empty) begin
                        ph_q <= PH_GROW;
                    end
                end
                PH_GROW: begin
                    err_evt = any_fall;
                    if (n_full) begin
                        ph_q     <= PH_DATA;
                        wave_cnt <= wave_cnt + CNT_W'(1);
                    end else if (n_empty) begin
                        // Data wavefront retracted before completing.
                        ph_q    <= PH_NULL;
                        err_evt = 1'b1;
                    end
                end
                PH_DATA: begin
                    if (n_empty) begin
                        ph_q <= PH_NULL;
                    end else if (!n_full) begin
                        ph_q <= PH_SHRINK;
                    end
                end
                default: begin
                    err_evt = any_rise;
                    if (n_empty) begin
                        ph_q <= PH_NULL;
                    end else if (n_full) begin
                        // NULL wavefront reversed back into DATA.
                        ph_q     <= PH_DATA;
                        wave_cnt <= wave_cnt + CNT_W'(1);
                        err_evt  = 1'b1;
                    end
                end
            endcase
            if (err_evt) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule
